ahb_slave_if_gen: RTL and testbench

//  Parametrised AHB-side front end of the AHB2APB bridge.
//  - Pipelines address, control and write data over two stages for the APB FSM.
//  - Qualifies each transfer (valid) and decodes the target APB slave one-hot (temp_sel).
//  - New in this generation: hready_in stall-hold, and a two-cycle AHB ERROR response for unmapped addresses.

---
 rtl/ahb_slave_if_gen_pkg.sv | 18 +
 rtl/ahb_slave_if_gen_if.sv | 41 ++++
 rtl/ahb_slave_if_gen_addr_decoder.sv | 29 ++
 rtl/ahb_slave_if_gen.sv | 110 +++++++++++
 tb/tb_ahb_slave_if_gen.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ahb_slave_if_gen_pkg.sv
// ahb_pkg: AHB transfer/response encodings and error-FSM state type for ahb_slave_if_gen.
`default_nettype none
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } err_state_t;
endpackage
`default_nettype wire

// File: rtl/ahb_slave_if_gen_if.sv
// ahb_slave_if_gen_if: AHB-side bus bundle between the AHB master and the bridge front end.
`default_nettype none
interface ahb_slave_if_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 3
) ();
    logic              hwrite;
    logic              hready_in;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] pr_data;

    logic               valid;
    logic [NUM_SEL-1:0] temp_sel;
    logic [ADDR_W-1:0]  haddr1;
    logic [ADDR_W-1:0]  haddr2;
    logic [DATA_W-1:0]  hwdata1;
    logic [DATA_W-1:0]  hwdata2;
    logic               hwrite_reg1;
    logic               hwrite_reg2;
    logic [2:0]         hsize_reg;
    logic [DATA_W-1:0]  hr_data;
    logic [1:0]         hresp;
    logic               hready_err;

    modport slave (
        input  hwrite, hready_in, htrans, hsize, haddr, hwdata, pr_data,
        output valid, temp_sel, haddr1, haddr2, hwdata1, hwdata2,
               hwrite_reg1, hwrite_reg2, hsize_reg, hr_data, hresp, hready_err
    );

    modport master (
        output hwrite, hready_in, htrans, hsize, haddr, hwdata, pr_data,
        input  valid, temp_sel, haddr1, haddr2, hwdata1, hwdata2,
               hwrite_reg1, hwrite_reg2, hsize_reg, hr_data, hresp, hready_err
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_if_gen_addr_decoder.sv
// ahb_addr_decoder: window check and one-hot APB slave select from haddr.
`default_nettype none
module ahb_addr_decoder #(
    parameter int               ADDR_W    = 32,
    parameter int               NUM_SEL   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SZ = 32'h0400_0000
) (
    input  wire logic [ADDR_W-1:0]  haddr_i,
    output logic                    mapped_o,
    output logic [NUM_SEL-1:0]      temp_sel_o
);
    localparam int C_SHIFT = $clog2(REGION_SZ);
    // One extra bit so a window ending at the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] C_LIMIT = {1'b0, BASE_ADDR}
                                        + (ADDR_W+1)'(NUM_SEL) * {1'b0, REGION_SZ};

    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_idx;

    assign mapped_o = ({1'b0, haddr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr_i} < C_LIMIT);
    assign w_offset = haddr_i - BASE_ADDR;
    assign w_idx    = w_offset >> C_SHIFT;

    for (genvar i = 0; i < NUM_SEL; i++) begin : g_sel
        assign temp_sel_o[i] = mapped_o && (w_idx == ADDR_W'(i));
    end
endmodule
`default_nettype wire

// File: rtl/ahb_slave_if_gen.sv
// ahb_slave_if_gen: AHB front end of the AHB2APB bridge - two-stage pipeline, decode, ERROR response.
`default_nettype none
module ahb_slave_if_gen
    import ahb_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 32,
    parameter int               NUM_SEL   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] REGION_SZ = 32'h0400_0000
) (
    input wire logic          hclk,
    input wire logic          hresetn,
    ahb_slave_if_gen_if.slave bus
);
    err_state_t        state_q;
    logic [1:0]        hresp_q;
    logic              hready_err_q;
    logic [ADDR_W-1:0] haddr1_q, haddr2_q;
    logic [DATA_W-1:0] hwdata1_q, hwdata2_q;
    logic              hwrite1_q, hwrite2_q;
    logic [2:0]        hsize_q;

    logic               w_active;
    logic               w_mapped;
    logic               w_unmapped_hit;
    logic [NUM_SEL-1:0] w_sel;

    ahb_addr_decoder #(
        .ADDR_W    (ADDR_W),
        .NUM_SEL   (NUM_SEL),
        .BASE_ADDR (BASE_ADDR),
        .REGION_SZ (REGION_SZ)
    ) u_dec (
        .haddr_i    (bus.haddr),
        .mapped_o   (w_mapped),
        .temp_sel_o (w_sel)
    );

    assign w_active       = bus.hready_in &&
                            ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
    assign w_unmapped_hit = w_active && !w_mapped;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
            hsize_q   <= '0;
        end else if (bus.hready_in) begin
            haddr1_q  <= bus.haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= bus.hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= bus.hwrite;
            hwrite2_q <= hwrite1_q;
            hsize_q   <= bus.hsize;
        end
    end

    // Two-cycle ERROR: first cycle stalls the master, second lets it see the response with HREADY high.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= IDLE;
            hresp_q      <= HRESP_OKAY;
            hready_err_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, ERR2: begin
                    if (w_unmapped_hit) begin
                        state_q      <= ERR1;
                        hresp_q      <= HRESP_ERROR;
                        hready_err_q <= 1'b0;
                    end else begin
                        state_q      <= IDLE;
                        hresp_q      <= HRESP_OKAY;
                        hready_err_q <= 1'b1;
                    end
                end
                ERR1: begin
                    state_q      <= ERR2;
                    hresp_q      <= HRESP_ERROR;
                    hready_err_q <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    hresp_q      <= HRESP_OKAY;
                    hready_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.valid       = w_active && w_mapped && (state_q != ERR1);
    assign bus.temp_sel    = w_sel;
    assign bus.haddr1      = haddr1_q;
    assign bus.haddr2      = haddr2_q;
    assign bus.hwdata1     = hwdata1_q;
    assign bus.hwdata2     = hwdata2_q;
    assign bus.hwrite_reg1 = hwrite1_q;
    assign bus.hwrite_reg2 = hwrite2_q;
    assign bus.hsize_reg   = hsize_q;
    assign bus.hr_data     = bus.pr_data;
    assign bus.hresp       = hresp_q;
    assign bus.hready_err  = hready_err_q;
endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_if_gen.sv
// tb_ahb_slave_if_gen: directed self-checking bench for ahb_slave_if_gen.
`default_nettype none
module tb_ahb_slave_if_gen;
    import ahb_pkg::*;

    logic hclk;
    logic hresetn;
    int   checks;
    int   errors;

    ahb_slave_if_gen_if #(.ADDR_W(32), .DATA_W(32), .NUM_SEL(3)) bus ();

    ahb_slave_if_gen #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_SEL   (3),
        .BASE_ADDR (32'h8000_0000),
        .REGION_SZ (32'h0400_0000)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus.slave)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic wr, input logic rdy,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.htrans    = tr;
        bus.hwrite    = wr;
        bus.hready_in = rdy;
        bus.haddr     = addr;
        bus.hwdata    = wdata;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hresetn       = 1'b1;
        bus.hsize     = 3'd0;
        bus.pr_data   = 32'hDEAD_BEEF;
        drive(HTRANS_IDLE, 1'b0, 1'b1, 32'h0, 32'h0);

        // Reset asserted mid-cycle, checked before the first edge
        #1 hresetn = 1'b0;
        #1;
        chk("rst_haddr1",     64'(bus.haddr1),      64'h0);
        chk("rst_haddr2",     64'(bus.haddr2),      64'h0);
        chk("rst_hwdata1",    64'(bus.hwdata1),     64'h0);
        chk("rst_hwdata2",    64'(bus.hwdata2),     64'h0);
        chk("rst_hwrite1",    64'(bus.hwrite_reg1), 64'h0);
        chk("rst_hwrite2",    64'(bus.hwrite_reg2), 64'h0);
        chk("rst_hsize",      64'(bus.hsize_reg),   64'h0);
        chk("rst_hresp",      64'(bus.hresp),       64'h0);
        chk("rst_hready_err", 64'(bus.hready_err),  64'h1);
        chk("rst_valid",      64'(bus.valid),       64'h0);
        chk("hr_data_pass",   64'(bus.hr_data),     64'hDEAD_BEEF);
        tick();
        tick();
        hresetn = 1'b1;

        // Mapped NONSEQ write to slave 1
        bus.hsize = 3'd2;
        drive(HTRANS_NONSEQ, 1'b1, 1'b1, 32'h8400_0010, 32'hA5A5_0001);
        chk("wr_valid",    64'(bus.valid),    64'h1);
        chk("wr_temp_sel", 64'(bus.temp_sel), 64'b010);
        tick();
        chk("wr_haddr1",  64'(bus.haddr1),      64'h8400_0010);
        chk("wr_hwdata1", 64'(bus.hwdata1),     64'hA5A5_0001);
        chk("wr_hwrite1", 64'(bus.hwrite_reg1), 64'h1);
        chk("wr_hsize",   64'(bus.hsize_reg),   64'h2);
        chk("wr_haddr2",  64'(bus.haddr2),      64'h0);
        chk("wr_hresp",   64'(bus.hresp),       64'h0);
        bus.hsize = 3'd0;
        drive(HTRANS_IDLE, 1'b0, 1'b1, 32'h0000_1000, 32'h0);
        tick();
        chk("p2_haddr2",  64'(bus.haddr2),      64'h8400_0010);
        chk("p2_hwdata2", 64'(bus.hwdata2),     64'hA5A5_0001);
        chk("p2_hwrite2", 64'(bus.hwrite_reg2), 64'h1);
        chk("p2_haddr1",  64'(bus.haddr1),      64'h0000_1000);

        // Three stalled cycles: pipeline holds
        drive(HTRANS_NONSEQ, 1'b1, 1'b0, 32'h8000_0004, 32'h0000_1234);
        chk("stall_valid",    64'(bus.valid),    64'h0);
        chk("stall_temp_sel", 64'(bus.temp_sel), 64'b001);
        tick();
        tick();
        tick();
        chk("stall_haddr1",  64'(bus.haddr1),      64'h0000_1000);
        chk("stall_haddr2",  64'(bus.haddr2),      64'h8400_0010);
        chk("stall_hwdata1", 64'(bus.hwdata1),     64'h0);
        chk("stall_hwdata2", 64'(bus.hwdata2),     64'hA5A5_0001);
        chk("stall_hwrite1", 64'(bus.hwrite_reg1), 64'h0);
        chk("stall_hwrite2", 64'(bus.hwrite_reg2), 64'h1);
        chk("stall_hresp",   64'(bus.hresp),       64'h0);
        bus.hready_in = 1'b1;
        #1;
        chk("unstall_valid", 64'(bus.valid), 64'h1);
        tick();
        chk("resume_haddr1", 64'(bus.haddr1), 64'h8000_0004);
        chk("resume_haddr2", 64'(bus.haddr2), 64'h0000_1000);

        // Unmapped NONSEQ at top-of-window
        drive(HTRANS_NONSEQ, 1'b0, 1'b1, 32'h8C00_0000, 32'h0);
        chk("top_valid",    64'(bus.valid),    64'h0);
        chk("top_temp_sel", 64'(bus.temp_sel), 64'h0);
        tick();
        drive(HTRANS_IDLE, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("err1_hresp",      64'(bus.hresp),      64'h1);
        chk("err1_hready_err", 64'(bus.hready_err), 64'h0);
        tick();
        chk("err2_hresp",      64'(bus.hresp),      64'h1);
        chk("err2_hready_err", 64'(bus.hready_err), 64'h1);
        tick();
        chk("idle_hresp",      64'(bus.hresp),      64'h0);
        chk("idle_hready_err", 64'(bus.hready_err), 64'h1);

        // Window edges, combinational only
        drive(HTRANS_NONSEQ, 1'b0, 1'b1, 32'h8BFF_FFFF, 32'h0);
        chk("last_valid",    64'(bus.valid),    64'h1);
        chk("last_temp_sel", 64'(bus.temp_sel), 64'b100);
        drive(HTRANS_SEQ, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0);
        chk("below_valid",    64'(bus.valid),    64'h0);
        chk("below_temp_sel", 64'(bus.temp_sel), 64'h0);

        // BUSY and IDLE never qualify nor error
        drive(HTRANS_BUSY, 1'b0, 1'b1, 32'h8000_0000, 32'h0);
        chk("busy_valid", 64'(bus.valid), 64'h0);
        tick();
        chk("busy_hresp", 64'(bus.hresp), 64'h0);
        drive(HTRANS_IDLE, 1'b0, 1'b1, 32'h8000_0000, 32'h0);
        chk("idle_valid", 64'(bus.valid), 64'h0);
        tick();
        chk("idle2_hresp", 64'(bus.hresp), 64'h0);

        // Reset during ERR1
        drive(HTRANS_NONSEQ, 1'b0, 1'b1, 32'h9000_0000, 32'h0);
        tick();
        drive(HTRANS_IDLE, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("pre_rst_hresp", 64'(bus.hresp), 64'h1);
        #1 hresetn = 1'b0;
        #1;
        chk("rst_err1_hresp",      64'(bus.hresp),      64'h0);
        chk("rst_err1_hready_err", 64'(bus.hready_err), 64'h1);
        chk("rst_err1_haddr1",     64'(bus.haddr1),     64'h0);
        tick();
        hresetn = 1'b1;

        // Back-to-back unmapped: ERR1, ERR2, ERR1; then mapped in ERR1/ERR2
        drive(HTRANS_NONSEQ, 1'b0, 1'b1, 32'h9000_0000, 32'h0);
        tick();
        chk("b2b_err1_hready_err", 64'(bus.hready_err), 64'h0);
        tick();
        chk("b2b_err2_hresp",      64'(bus.hresp),      64'h1);
        chk("b2b_err2_hready_err", 64'(bus.hready_err), 64'h1);
        tick();
        chk("b2b_reerr1_hresp",      64'(bus.hresp),      64'h1);
        chk("b2b_reerr1_hready_err", 64'(bus.hready_err), 64'h0);
        drive(HTRANS_NONSEQ, 1'b0, 1'b1, 32'h8000_0000, 32'h0);
        chk("err1_mapped_valid", 64'(bus.valid), 64'h0);
        tick();
        chk("err2_mapped_valid",    64'(bus.valid),    64'h1);
        chk("err2_mapped_temp_sel", 64'(bus.temp_sel), 64'b001);
        drive(HTRANS_IDLE, 1'b0, 1'b1, 32'h0, 32'h0);
        tick();
        chk("final_hresp",      64'(bus.hresp),      64'h0);
        chk("final_hready_err", 64'(bus.hready_err), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
